// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - opcode and FSM state types shared by accumulator_pipe
package accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - W-bit carry-lookahead adder slice
module cla_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   carry;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded from generate/propagate terms and cin only, never from another carry.
  always_comb begin
    logic t;
    carry = '0;
    t     = 1'b0;
    for (int i = 0; i <= W; i++) begin
      t = cin;
      for (int j = 0; j < i; j++) begin
        t = g[j] | (p[j] & t);
      end
      carry[i] = t;
    end
  end

  assign sum  = p ^ carry[W-1:0];
  assign cout = carry[W];

endmodule

// File: rtl/accumulator_pipe.sv
// rtl/accumulator_pipe.sv - two-stage split-half accumulator with one-entry hold register
// ACCUM_SATURATE_EN: clamp on ADD overflow / SUB borrow instead of wrapping.
module accumulator_pipe
  import accum_pkg::*;
#(
  parameter int OPERAND_W = 8,
  parameter int ACC_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [OPERAND_W-1:0] in_operand,
  output logic [ACC_W-1:0]     acc_value,
  output logic                 acc_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int LO_W = ACC_W / 2;
  localparam int HI_W = ACC_W - LO_W;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [OPERAND_W-1:0] opnd_q, opnd_d;
  logic                 hold_valid_q, hold_valid_d;
  op_e                  hold_op_q, hold_op_d;
  logic [OPERAND_W-1:0] hold_opnd_q, hold_opnd_d;
  logic [LO_W-1:0]      lo_sum_q, lo_sum_d;
  logic                 carry_lo_q, carry_lo_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 acc_valid_q, acc_valid_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] addend;
  logic             sub_cin;
  logic [LO_W-1:0]  lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;
  logic             xfer;
  logic             add_ovf;
  logic             sub_bor;

  assign ext  = ACC_W'(opnd_q);
  assign xfer = in_valid && in_ready;

  // LOAD and CLEAR reuse the adders with a zero base so every op takes the same path.
  always_comb begin
    base    = acc_q;
    addend  = ext;
    sub_cin = 1'b0;
    case (op_q)
      OP_ADD:  ;
      OP_SUB:  begin addend = ~ext; sub_cin = 1'b1; end
      OP_LOAD: base = '0;
      default: begin base = '0; addend = '0; end
    endcase
  end

  cla_slice #(.W(LO_W)) u_lo (
    .a(base[LO_W-1:0]), .b(addend[LO_W-1:0]), .cin(sub_cin), .sum(lo_sum), .cout(lo_cout)
  );

  cla_slice #(.W(HI_W)) u_hi (
    .a(base[ACC_W-1:LO_W]), .b(addend[ACC_W-1:LO_W]), .cin(carry_lo_q), .sum(hi_sum), .cout(hi_cout)
  );

  assign add_ovf = (op_q == OP_ADD) && hi_cout;
  assign sub_bor = (op_q == OP_SUB) && !hi_cout;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    opnd_d       = opnd_q;
    hold_valid_d = hold_valid_q;
    hold_op_d    = hold_op_q;
    hold_opnd_d  = hold_opnd_q;
    lo_sum_d     = lo_sum_q;
    carry_lo_d   = carry_lo_q;
    acc_d        = acc_q;
    acc_valid_d  = 1'b0;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          op_d    = op_e'(in_op);
          opnd_d  = in_operand;
          state_d = LO;
        end
      end
      LO: begin
        lo_sum_d   = lo_sum;
        carry_lo_d = lo_cout;
        state_d    = HI;
        if (xfer) begin
          hold_valid_d = 1'b1;
          hold_op_d    = op_e'(in_op);
          hold_opnd_d  = in_operand;
        end
      end
      HI: begin
        acc_d       = {hi_sum, lo_sum_q};
        acc_valid_d = 1'b1;
`ifdef ACCUM_SATURATE_EN
        if (add_ovf) begin
          acc_d = '1;
        end else if (sub_bor) begin
          acc_d = '0;
        end
`endif
        if (op_q == OP_CLEAR) begin
          ovf_d = 1'b0;
        end else if (add_ovf || sub_bor) begin
          ovf_d = 1'b1;
        end
        if (hold_valid_q) begin
          op_d         = hold_op_q;
          opnd_d       = hold_opnd_q;
          hold_valid_d = 1'b0;
          state_d      = LO;
        end else if (xfer) begin
          op_d    = op_e'(in_op);
          opnd_d  = in_operand;
          state_d = LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_q         <= OP_ADD;
      opnd_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_op_q    <= OP_ADD;
      hold_opnd_q  <= '0;
      lo_sum_q     <= '0;
      carry_lo_q   <= 1'b0;
      acc_q        <= '0;
      acc_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      hold_valid_q <= hold_valid_d;
      hold_op_q    <= hold_op_d;
      hold_opnd_q  <= hold_opnd_d;
      lo_sum_q     <= lo_sum_d;
      carry_lo_q   <= carry_lo_d;
      acc_q        <= acc_d;
      acc_valid_q  <= acc_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign in_ready  = !hold_valid_q;
  assign acc_value = acc_q;
  assign acc_valid = acc_valid_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || hold_valid_q;

endmodule

// File: tb/tb_accumulator_pipe.sv
// tb/tb_accumulator_pipe.sv - self-checking bench for accumulator_pipe (16-bit and 8-bit instances)
module tb_accumulator_pipe;

`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [7:0]  in_operand;
  logic [15:0] acc_value;
  logic        acc_valid;
  logic        overflow;
  logic        busy;

  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_op;
  logic [3:0]  s_operand;
  logic [7:0]  s_acc;
  logic        s_acc_valid;
  logic        s_ovf;
  logic        s_busy;

  int tests_run = 0;
  int fails     = 0;
  int m_acc;
  bit m_ovf;
  int sm_acc;
  bit sm_ovf;

  always #5 clk = ~clk;

  accumulator_pipe #(.OPERAND_W(8), .ACC_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_operand(in_operand), .acc_value(acc_value),
    .acc_valid(acc_valid), .overflow(overflow), .busy(busy)
  );

  accumulator_pipe #(.OPERAND_W(4), .ACC_W(8)) dut_small (
    .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_op(s_op), .in_operand(s_operand), .acc_value(s_acc),
    .acc_valid(s_acc_valid), .overflow(s_ovf), .busy(s_busy)
  );

  // Reference: plain integer arithmetic on the running value.
  function automatic void model_step(input int w, input logic [1:0] op, input int x,
                                     input int acc_in, input bit ovf_in,
                                     output int acc_out, output bit ovf_out);
    int maxv;
    maxv    = (1 << w) - 1;
    acc_out = acc_in;
    ovf_out = ovf_in;
    case (op)
      2'b00: begin
        if (acc_in + x > maxv) begin
          ovf_out = 1'b1;
          acc_out = SAT ? maxv : acc_in + x - (maxv + 1);
        end else begin
          acc_out = acc_in + x;
        end
      end
      2'b01: begin
        if (x > acc_in) begin
          ovf_out = 1'b1;
          acc_out = SAT ? 0 : acc_in - x + maxv + 1;
        end else begin
          acc_out = acc_in - x;
        end
      end
      2'b10:   acc_out = x;
      default: begin acc_out = 0; ovf_out = 1'b0; end
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] x);
    bit rdy;
    int n;
    in_op      = op;
    in_operand = x;
    in_valid   = 1'b1;
    n          = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    if (!rdy) begin
      tests_run++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_valid(output bit got);
    int n;
    n = 0;
    while (!acc_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    got = acc_valid;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] x, output bit got);
    send(op, x);
    model_step(16, op, int'(x), m_acc, m_ovf, m_acc, m_ovf);
    wait_valid(got);
  endtask

  task automatic run_small(input logic [1:0] op, input logic [3:0] x, output bit got);
    bit rdy;
    int n;
    s_op = op; s_operand = x; s_valid = 1'b1; n = 0;
    do begin
      rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    s_valid = 1'b0;
    model_step(8, op, int'(x), sm_acc, sm_ovf, sm_acc, sm_ovf);
    n = 0;
    while (!s_acc_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    got = rdy && s_acc_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_operand = '0;
    s_valid = 1'b0; s_op = 2'b00; s_operand = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    m_acc = 0; m_ovf = 1'b0; sm_acc = 0; sm_ovf = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (acc_value !== 16'h0000) begin fails++; $display("FAIL reset_acc: got %h want 0000", acc_value); end
    tests_run++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", acc_valid); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_carry();
    bit got;
    send(2'b00, 8'hFF);
    model_step(16, 2'b00, 255, m_acc, m_ovf, m_acc, m_ovf);
    tests_run++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL carry_e0_valid: got %b want 0", acc_valid); end
    @(posedge clk); #1;
    tests_run++; if (acc_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL carry_e1: valid %b busy %b want 0 1", acc_valid, busy); end
    @(posedge clk); #1;
    tests_run++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL carry_e2_valid: got %b want 1", acc_valid); end
    tests_run++; if (acc_value !== 16'h00FF) begin fails++; $display("FAIL carry_first: got %h want 00ff", acc_value); end
    @(posedge clk); #1;
    tests_run++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL carry_pulse_width: got %b want 0", acc_valid); end
    run_op(2'b00, 8'h01, got);
    tests_run++; if (!got || acc_value !== 16'h0100) begin fails++; $display("FAIL carry_second: got %h want 0100", acc_value); end
  endtask

  task automatic test_overflow();
    bit got;
    run_op(2'b11, 8'h00, got);
    for (int i = 0; i < 256; i++) run_op(2'b00, 8'hFF, got);
    run_op(2'b00, 8'hF0, got);
    tests_run++; if (!got || acc_value !== 16'hFFF0 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_setup: got %h/%b want fff0/0", acc_value, overflow); end
    run_op(2'b00, 8'h20, got);
    tests_run++; if (!got || acc_value !== m_acc[15:0]) begin fails++; $display("FAIL ovf_add_value: got %h want %h", acc_value, m_acc[15:0]); end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_add_flag: got %b want 1", overflow); end
  endtask

  task automatic test_sub_clear();
    bit got;
    run_op(2'b11, 8'h00, got);
    run_op(2'b10, 8'h05, got);
    run_op(2'b01, 8'h07, got);
    tests_run++; if (!got || acc_value !== m_acc[15:0]) begin fails++; $display("FAIL sub_borrow_value: got %h want %h", acc_value, m_acc[15:0]); end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL sub_borrow_flag: got %b want 1", overflow); end
    run_op(2'b11, 8'hAA, got);
    tests_run++; if (!got || acc_value !== 16'h0000 || overflow !== 1'b0) begin fails++; $display("FAIL clear: got %h/%b want 0000/0", acc_value, overflow); end
  endtask

  task automatic test_back_to_back();
    bit pre;
    int accepted;
    accepted   = 0;
    in_op      = 2'b00;
    in_operand = 8'h01;
    in_valid   = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      pre = in_valid && in_ready;
      @(posedge clk); #1;
      if (pre) accepted++;
      if (accepted == 4) in_valid = 1'b0;
      tests_run++;
      if (in_ready !== !((k % 2 == 1) && (k <= 5))) begin
        fails++; $display("FAIL b2b_ready_e%0d: got %b want %b", k, in_ready, !((k % 2 == 1) && (k <= 5)));
      end
      tests_run++;
      if (acc_valid !== ((k % 2 == 0) && (k >= 2))) begin
        fails++; $display("FAIL b2b_valid_e%0d: got %b", k, acc_valid);
      end else if (acc_valid && acc_value !== 16'(k / 2)) begin
        fails++; $display("FAIL b2b_value_e%0d: got %h want %h", k, acc_value, 16'(k / 2));
      end
    end
    in_valid = 1'b0;
    m_acc = 4;
    tests_run++; if (accepted !== 4) begin fails++; $display("FAIL b2b_accepted: got %0d want 4", accepted); end
    @(posedge clk); #1;
    tests_run++; if (acc_value !== 16'h0004 || busy !== 1'b0) begin fails++; $display("FAIL b2b_final: got %h busy %b want 0004 0", acc_value, busy); end
  endtask

  task automatic test_reset_mid();
    bit got;
    run_op(2'b11, 8'h00, got);
    run_op(2'b01, 8'h01, got);
    run_op(2'b10, 8'h42, got);
    in_op = 2'b00; in_operand = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++; if (in_ready !== 1'b0 || busy !== 1'b1 || overflow !== 1'b1) begin fails++; $display("FAIL mid_pre: ready %b busy %b ovf %b want 0 1 1", in_ready, busy, overflow); end
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    tests_run++; if (acc_value !== 16'h0000 || acc_valid !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL mid_reset_out: acc %h valid %b ovf %b want 0000 0 0", acc_value, acc_valid, overflow); end
    tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL mid_reset_hs: ready %b busy %b want 1 0", in_ready, busy); end
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_acc = 0; m_ovf = 1'b0; sm_acc = 0; sm_ovf = 1'b0;
    @(posedge clk); #1;
    run_op(2'b00, 8'h03, got);
    tests_run++; if (!got || acc_value !== 16'h0003 || overflow !== 1'b0) begin fails++; $display("FAIL mid_after: got %h/%b want 0003/0", acc_value, overflow); end
    @(posedge clk); #1;
    tests_run++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL mid_no_stale_op: acc_valid %b want 0", acc_valid); end
  endtask

  task automatic test_random();
    bit got;
    logic [1:0] op;
    logic [7:0] x;
    int r;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      x  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op(op, x, got);
      tests_run++;
      if (!got || acc_value !== m_acc[15:0] || overflow !== m_ovf) begin
        fails++; $display("FAIL rand_%0d op %0d x %h: got %h/%b want %h/%b", i, op, x, acc_value, overflow, m_acc[15:0], m_ovf);
      end
    end
  endtask

  task automatic test_small();
    bit got;
    bit all_ok;
    all_ok = 1'b1;
    run_small(2'b11, 4'h0, got);
    for (int i = 0; i < 17; i++) begin
      run_small(2'b00, 4'hF, got);
      if (!got) all_ok = 1'b0;
    end
    tests_run++; if (!all_ok || s_acc !== 8'hFF || s_ovf !== 1'b0) begin fails++; $display("FAIL small_fill: got %h/%b want ff/0", s_acc, s_ovf); end
    run_small(2'b00, 4'h1, got);
    tests_run++; if (!got || s_acc !== sm_acc[7:0] || s_ovf !== 1'b1) begin fails++; $display("FAIL small_ovf: got %h/%b want %h/1", s_acc, s_ovf, sm_acc[7:0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_carry();
    test_overflow();
    test_sub_clear();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
